// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of the single-port synchronous data RAM.
// Port 0 is the CPU load/store path, port 1 is a DMA/debug master. One access is
// granted per cycle, read data returns one cycle after the grant, the DMA port is
// protected from CPU starvation, and the DMA can lock ownership for a burst.
module dmem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4    // 1..15: CPU grants tolerated while DMA waits
) (
  input  logic              clock,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  // RAM side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    ARB  = 1'b0,   // normal arbitration with starvation guard
    LOCK = 1'b1    // DMA burst owns the RAM
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  owner_e     rd_owner_q, rd_owner_d;

  logic lock_hold;   // LOCK state and the burst is still being requested
  logic starved;     // DMA has waited through the maximum CPU run

  assign lock_hold = (state_q == LOCK) && dma_req && dma_lock;
  assign starved   = (starve_cnt_q == STARVE_LIM);

  // State register: reset always returns to ARB.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a DMA grant with lock held enters (or stays in) LOCK; any cycle
  // where the burst is released falls back to ARB.
  // NOTE: every signal assigned in a combinational block gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB: begin
        if (dma_gnt && dma_lock) state_d = LOCK;
      end
      LOCK: begin
        if (!dma_req || !dma_lock) state_d = ARB;
        else if (dma_gnt)          state_d = LOCK;
      end
      default: state_d = ARB;
    endcase
  end

  // Grant outputs: LOCK gives DMA absolute priority; otherwise a lone requester wins
  // and a tie goes to the CPU until the DMA has been starved STARVE_MAX times.
  // A released lock (req or lock low) is arbitrated exactly like ARB.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (lock_hold) begin
        dma_gnt = 1'b1;
      end else if (cpu_req && dma_req) begin
        if (starved) dma_gnt = 1'b1;
        else         cpu_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  // Starvation counter next value: counts CPU wins over a waiting DMA, saturating,
  // and clears as soon as the DMA is served or stops asking.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (dma_gnt || !dma_req) begin
      starve_cnt_d = 4'd0;
    end else if (cpu_gnt && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Read-return owner next value: remembers which port issued this cycle's read.
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we)      rd_owner_d = OWN_CPU;
    else if (dma_gnt && !dma_we) rd_owner_d = OWN_DMA;
  end

  // Starvation counter and read-return owner registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
      rd_owner_q   <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // RAM request mux: drive the granted port's command, all zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // Stall freezes the PC while the CPU waits; reset masks the stale read owner so a
  // read granted just before reset never returns.
  assign cpu_stall  = cpu_req && !cpu_gnt && !reset;
  assign cpu_rvalid = (rd_owner_q == OWN_CPU) && !reset;
  assign dma_rvalid = (rd_owner_q == OWN_DMA) && !reset;

  // Both ports see the RAM output directly; consumers qualify it with rvalid.
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plan scenarios followed by constrained-random traffic.
// A behavioural model predicts grants and the RAM command every cycle; predicted
// read returns go into a queue that an independent monitor drains against rvalid.
module tb_dmem_arbiter;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req, dma_we, dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit          to_dma;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  logic [31:0] ram     [0:63];
  logic [31:0] ref_mem [0:63];
  bit          ram_ready = 1'b0;

  // Model state: whether a DMA burst currently owns the RAM, and how many times in a
  // row the CPU has won while the DMA was waiting.
  bit m_dma_owns;
  int m_streak;
  int last_win;     // 0 none, 1 cpu, 2 dma

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int a);
    if (a == 16) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  // Synchronous RAM: loads its initial image on the first edge, then serves
  // commands with read data one cycle after the request.
  always @(posedge clock) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model for one cycle: decide the winner from the arbitration rules,
  // compare the DUT's combinational outputs, record reads/writes, advance model state.
  task automatic model_step();
    int          win;
    logic        e_we;
    logic [13:0] e_addr;
    logic [31:0] e_wd;
    win = 0;
    if (!reset) begin
      if (m_dma_owns && dma_req && dma_lock)   win = 2;
      else if (cpu_req && dma_req)             win = (m_streak >= STARVE_MAX) ? 2 : 1;
      else if (cpu_req)                        win = 1;
      else if (dma_req)                        win = 2;
    end
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (win == 1) begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
    if (win == 2) begin e_we = dma_we; e_addr = dma_addr; e_wd = dma_wdata; end

    check("cpu_gnt",   64'(cpu_gnt),   64'(win == 1));
    check("dma_gnt",   64'(dma_gnt),   64'(win == 2));
    check("cpu_stall", 64'(cpu_stall), 64'(!reset && cpu_req && win != 1));
    check("mem_en",    64'(mem_en),    64'(win != 0));
    check("mem_we",    64'(mem_we),    64'(e_we));
    check("mem_addr",  64'(mem_addr),  64'(e_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wd));

    if (win != 0) begin
      if (e_we) ref_mem[e_addr[5:0]] = e_wd;
      else      exp_q.push_back('{to_dma: (win == 2), data: ref_mem[e_addr[5:0]], due: cyc + 1});
    end

    if (reset) begin
      m_dma_owns = 1'b0;
      m_streak   = 0;
    end else begin
      m_dma_owns = (win == 2) && dma_lock;
      if (win == 2 || !dma_req)            m_streak = 0;
      else if (win == 1 && m_streak < STARVE_MAX) m_streak++;
    end
    last_win = win;
  endtask

  task automatic tick();
    @(negedge clock);
    model_step();
    @(posedge clock);
    #1;
  endtask

  // One cycle with an additional comparison of {cpu_gnt,dma_gnt} against a plan pattern.
  task automatic tick_plan(input logic [1:0] exp_g, input string tag);
    @(negedge clock);
    model_step();
    check(tag, 64'({cpu_gnt, dma_gnt}), 64'(exp_g));
    @(posedge clock);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input int addr, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = 14'(addr); cpu_wdata = wd;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic lock, input int addr,
                         input logic [31:0] wd);
    dma_req = req; dma_we = we; dma_lock = lock; dma_addr = 14'(addr); dma_wdata = wd;
  endtask

  // Monitor: every cycle, compare rvalid/rdata with the oldest prediction due now.
  // A return due in a reset cycle is discarded: reset kills in-flight reads.
  initial begin
    forever begin
      @(negedge clock);
      begin : mon_body
        bit          ec, ed;
        logic [31:0] d;
        rd_exp_t     e;
        ec = 1'b0; ed = 1'b0; d = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          if (!reset) begin
            ec = !e.to_dma;
            ed = e.to_dma;
            d  = e.data;
          end
        end
        check("cpu_rvalid", 64'(cpu_rvalid), 64'(ec));
        check("dma_rvalid", 64'(dma_rvalid), 64'(ed));
        if (ec && cpu_rvalid) check("cpu_rdata", 64'(cpu_rdata), 64'(d));
        if (ed && dma_rvalid) check("dma_rdata", 64'(dma_rdata), 64'(d));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit c_pend, d_pend, prev_lock;
    int rst_left;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    m_dma_owns = 1'b0; m_streak = 0; last_win = 0;
    reset = 1'b1;
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    repeat (3) tick();
    reset = 1'b0;

    // Idle: nothing granted, nothing returned.
    for (int i = 0; i < 10; i++) tick_plan(2'b00, "idle_gnt");

    // Lone CPU read of the preloaded word.
    set_cpu(1, 0, 'h10, 0);
    tick_plan(2'b10, "lone_cpu_gnt");
    set_cpu(0, 0, 0, 0);
    @(negedge clock);
    model_step();
    check("lone_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("lone_cpu_rdata",  64'(cpu_rdata),  64'hDEADBEEF);
    check("lone_dma_rvalid", 64'(dma_rvalid), 64'd0);
    @(posedge clock); #1;

    // Continuous contention without lock: C,C,C,C,D repeating.
    set_cpu(1, 0, 1, 0);
    set_dma(1, 0, 0, 2, 0);
    for (int i = 0; i < 15; i++) tick_plan((i % 5 == 4) ? 2'b01 : 2'b10, "starve_gnt");
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    tick();

    // Locked DMA burst of three writes against a requesting CPU, then release.
    set_cpu(1, 0, 3, 0);
    set_dma(1, 1, 1, 'h20, 32'h12345678);
    for (int i = 0; i < 7; i++) tick_plan((i < 4) ? 2'b10 : 2'b01, "lock_gnt");
    dma_lock = 1'b0;
    tick_plan(2'b10, "lock_release_gnt");
    set_cpu(0, 0, 0, 0);
    set_dma(1, 0, 0, 'h20, 0);
    tick_plan(2'b01, "lock_readback_gnt");
    set_dma(0, 0, 0, 0, 0);
    @(negedge clock);
    model_step();
    check("lock_readback_rvalid", 64'(dma_rvalid), 64'd1);
    check("lock_readback_rdata",  64'(dma_rdata),  64'h12345678);
    @(posedge clock); #1;

    // Alternating CPU / DMA reads, back to back.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin set_cpu(1, 0, i, 0); set_dma(0, 0, 0, 0, 0); end
      else            begin set_cpu(0, 0, 0, 0); set_dma(1, 0, 0, i + 8, 0); end
      tick_plan((i % 2 == 0) ? 2'b10 : 2'b01, "alt_gnt");
    end
    set_dma(0, 0, 0, 0, 0);
    tick();

    // Reset right after a CPU read grant: no return, outputs quiet, clean restart.
    set_cpu(1, 0, 'h10, 0);
    tick_plan(2'b10, "pre_reset_gnt");
    set_cpu(1, 0, 5, 0);
    reset = 1'b1;
    tick_plan(2'b00, "in_reset_gnt");
    tick_plan(2'b00, "in_reset_gnt");
    reset = 1'b0;
    tick_plan(2'b10, "post_reset_gnt");
    set_cpu(0, 0, 0, 0);
    tick();

    // Random traffic: requests held until granted, occasional bursts and resets.
    c_pend = 1'b0; d_pend = 1'b0; prev_lock = 1'b0; rst_left = 0;
    for (int n = 0; n < 2500; n++) begin
      if (!c_pend) begin
        cpu_addr = 14'($urandom_range(0, 63));
        cpu_we   = ($urandom_range(0, 2) == 0);
        cpu_wdata = $urandom;
        if ($urandom_range(0, 99) < 60) c_pend = 1'b1;
      end
      if (!d_pend) begin
        dma_addr  = 14'($urandom_range(0, 63));
        dma_we    = ($urandom_range(0, 1) == 0);
        dma_wdata = $urandom;
        dma_lock  = ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 99) < (prev_lock ? 85 : 45)) d_pend = 1'b1;
      end
      cpu_req = c_pend;
      dma_req = d_pend;
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 2);
      reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      tick();
      if (last_win == 1) c_pend = 1'b0;
      if (last_win == 2) begin d_pend = 1'b0; prev_lock = dma_lock; end
    end

    reset = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
